// File: rtl/asm_run_counter_if.sv
// ---------------------------------------------------------------------------
// asm_run_counter_if
// Purpose : groups the run-request inputs and status outputs of
//           asm_run_counter into one bundle.
// Signals : start  - run request (honoured only while idle)
//           x      - qualifying event input
//           mode   - 0 = cumulative counting, 1 = consecutive counting
//           target - terminal count (0 means 2^WIDTH)
//           count  - registered event counter
//           done   - registered completion flag
//           busy   - high whenever the FSM is not idle
//           state  - FSM state code (IDLE=00, ARMED=01, COUNT=10)
// Modports: master drives requests / reads status, slave is the counter.
// ---------------------------------------------------------------------------
interface asm_run_counter_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             x;
    logic             mode;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output start, x, mode, target,
        input  count, done, busy, state
    );

    modport slave (
        input  start, x, mode, target,
        output count, done, busy, state
    );
endinterface

// File: rtl/asm_run_counter.sv
// ---------------------------------------------------------------------------
// asm_run_counter
// Purpose : ASM-style run counter. A start accepted in IDLE latches target
//           and mode, clears the counter and arms the block. Each x=1 while
//           armed/counting increments the counter; the run completes one
//           edge after the counter equals the latched target. In
//           consecutive mode (mode=1) a gap in x clears the counter.
// Ports   : clk   - single clock, rising edge
//           reset - synchronous, active-high reset
//           bus   - asm_run_counter_if.slave (start, x, mode, target in;
//                   count, done, busy, state out)
// Config  : ASM_RUN_COUNTER_STICKY_DONE_EN
//           undefined - done is a one-cycle pulse per completion
//           defined   - done stays set until the next accepted start or
//                       reset
// ---------------------------------------------------------------------------
module asm_run_counter #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    asm_run_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        COUNT = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             z;

    // Terminal condition; only consulted in COUNT. A target of 0 is met
    // after the counter wraps from all-ones back to 0.
    assign z = (count_q == target_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        mode_d   = mode_q;
`ifdef ASM_RUN_COUNTER_STICKY_DONE_EN
        done_d   = done_q;
`else
        done_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d  = '0;
                    target_d = bus.target;
                    mode_d   = bus.mode;
                    state_d  = ARMED;
                    done_d   = 1'b0;
                end
            end
            ARMED: begin
                if (bus.x) begin
                    count_d = count_q + ONE;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (z) begin
                    // Completion: x is ignored and count holds.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (bus.x) begin
                    count_d = count_q + ONE;
                end else begin
                    // Gap in the event stream: consecutive mode restarts.
                    state_d = ARMED;
                    if (mode_q) begin
                        count_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.state = state_q;

endmodule

// File: tb/tb_asm_run_counter.sv
module tb_asm_run_counter;

    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    asm_run_counter_if #(.WIDTH(WIDTH)) bus ();

    asm_run_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs set before the call are sampled there,
    // outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [1:0] st,
                                input logic [3:0] cnt, input logic dn);
        check({tag, ".state"}, {30'd0, bus.state}, {30'd0, st});
        check({tag, ".count"}, {28'd0, bus.count}, {28'd0, cnt});
        check({tag, ".done"},  {31'd0, bus.done},  {31'd0, dn});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.x      = 1'b0;
        bus.mode   = 1'b0;
        bus.target = 4'd0;
        #2;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check_status("reset", 2'b00, 4'd0, 1'b0);
        check("reset.busy", {31'd0, bus.busy}, 32'd0);

        // Cumulative run, target=5, x held high
        bus.target = 4'd5; bus.mode = 1'b0; bus.start = 1'b1; bus.x = 1'b0;
        step();
        bus.start = 1'b0;
        check_status("t5.start", 2'b01, 4'd0, 1'b0);
        check("t5.busy", {31'd0, bus.busy}, 32'd1);
        bus.x = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_status($sformatf("t5.inc%0d", i), 2'b10, 4'(i), 1'b0);
        end
        step();
        check_status("t5.done", 2'b00, 4'd5, 1'b1);
        step();
        check_status("t5.after", 2'b00, 4'd5, 1'b0);
        check("t5.idlebusy", {31'd0, bus.busy}, 32'd0);
        bus.x = 1'b0;

        // Cumulative with a gap: x = 1,0,1,1 -> 1,1,2,3, no clear
        bus.target = 4'd3; bus.mode = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_status("cum.start", 2'b01, 4'd0, 1'b0);
        bus.x = 1'b1; step(); check_status("cum.x1", 2'b10, 4'd1, 1'b0);
        bus.x = 1'b0; step(); check_status("cum.gap", 2'b01, 4'd1, 1'b0);
        bus.x = 1'b1; step(); check_status("cum.x3", 2'b10, 4'd2, 1'b0);
        bus.x = 1'b1; step(); check_status("cum.x4", 2'b10, 4'd3, 1'b0);
        bus.x = 1'b0; step(); check_status("cum.done", 2'b00, 4'd3, 1'b1);

        // Consecutive: x = 1,1,0,1,1,1 -> 1,2,0,1,2,3
        bus.target = 4'd3; bus.mode = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_status("con.start", 2'b01, 4'd0, 1'b0);
        bus.x = 1'b1; step(); check_status("con.x1", 2'b10, 4'd1, 1'b0);
        bus.x = 1'b1; step(); check_status("con.x2", 2'b10, 4'd2, 1'b0);
        bus.x = 1'b0; step(); check_status("con.gap", 2'b01, 4'd0, 1'b0);
        bus.x = 1'b1; step(); check_status("con.x4", 2'b10, 4'd1, 1'b0);
        bus.x = 1'b1; step(); check_status("con.x5", 2'b10, 4'd2, 1'b0);
        bus.x = 1'b1; step(); check_status("con.x6", 2'b10, 4'd3, 1'b0);
        bus.x = 1'b1; step(); check_status("con.done", 2'b00, 4'd3, 1'b1);
        bus.x = 1'b0;

        // Target 0 means 16 increments with wrap
        bus.target = 4'd0; bus.mode = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_status("wrap.start", 2'b01, 4'd0, 1'b0);
        bus.x = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_status($sformatf("wrap.inc%0d", i), 2'b10, 4'(i), 1'b0);
        end
        step();
        check_status("wrap.done", 2'b00, 4'd0, 1'b1);
        bus.x = 1'b0;

        // Mid-run start/target/mode changes ignored, then reset in COUNT
        bus.target = 4'd3; bus.mode = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.x = 1'b1; step(); check_status("mid.x1", 2'b10, 4'd1, 1'b0);
        bus.target = 4'd1; bus.mode = 1'b1; bus.start = 1'b1;
        bus.x = 1'b1; step(); check_status("mid.x2", 2'b10, 4'd2, 1'b0);
        bus.x = 1'b0; step(); check_status("mid.gap", 2'b01, 4'd2, 1'b0);
        bus.x = 1'b1; step(); check_status("mid.x3", 2'b10, 4'd3, 1'b0);
        reset = 1'b1;
        step();
        check_status("mid.reset", 2'b00, 4'd0, 1'b0);
        reset = 1'b0; bus.start = 1'b0; bus.x = 1'b0;
        step();
        check_status("mid.post", 2'b00, 4'd0, 1'b0);

        // Reset while ARMED aborts without a done pulse
        bus.target = 4'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_status("armrst.armed", 2'b01, 4'd0, 1'b0);
        reset = 1'b1; step(); reset = 1'b0;
        check_status("armrst.reset", 2'b00, 4'd0, 1'b0);
        step();
        check_status("armrst.post", 2'b00, 4'd0, 1'b0);

`ifdef ASM_RUN_COUNTER_STICKY_DONE_EN
        // Sticky done holds through IDLE until the next accepted start
        bus.target = 4'd2; bus.mode = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.x = 1'b1; step(); step();
        check_status("sticky.cnt2", 2'b10, 4'd2, 1'b0);
        step();
        check_status("sticky.done", 2'b00, 4'd2, 1'b1);
        bus.x = 1'b0;
        step(); step();
        check_status("sticky.hold", 2'b00, 4'd2, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_status("sticky.clear", 2'b01, 4'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
